// File: rtl/decrypt_stream_unit.sv
// Receive-side stream decryptor: dec = rotr(enc, ROT) ^ lfsr_key, 2-stage pipeline into an output FIFO.
// Optional saturating output byte counter when DECRYPT_BYTE_CNT_EN is defined.
module decrypt_stream_unit #(
  parameter int          ROT        = 3,
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        encrypted_data_valid,
  input  logic [7:0]  encrypted_data,
  output logic        in_ready,
  input  logic        key_load,
  input  logic [7:0]  key_seed,
  output logic [7:0]  decrypted_data,
  output logic        decrypt_valid_out,
  input  logic        out_ready
`ifdef DECRYPT_BYTE_CNT_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a byte moves on a port in any cycle where its valid and ready are both high
  // at the rising edge; valid is never withdrawn by the DUT once raised except by reset.
  logic [7:0]    key_q, key_d;
  logic          s1_valid_q, s1_valid_d;
  logic [7:0]    s1_data_q, s1_data_d;
  logic [7:0]    s1_key_q, s1_key_d;
  logic          s2_valid_q, s2_valid_d;
  logic [7:0]    s2_data_q, s2_data_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic [CW:0]   occupancy;
  logic          accept;
  logic          push;
  logic          pop;

  function automatic logic [7:0] rotr8(input logic [7:0] x);
    logic [15:0] d;
    d = {x, x} >> ROT;
    return d[7:0];
  endfunction

  // Credits cover every byte already committed to the FIFO, so the pipeline never needs to stall.
  assign occupancy         = {1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
  assign in_ready          = occupancy < (CW+1)'(FIFO_DEPTH);
  assign accept            = encrypted_data_valid && in_ready;
  assign push              = s2_valid_q;
  assign decrypt_valid_out = count_q != '0;
  assign pop               = decrypt_valid_out && out_ready;
  assign decrypted_data    = decrypt_valid_out ? mem_q[rd_ptr_q] : last_q;

  always_comb begin
    key_d      = key_q;
    s1_valid_d = accept;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    last_d     = last_q;
    if (accept) begin
      s1_data_d = rotr8(encrypted_data);
      s1_key_d  = key_q;
    end
    // A resync wins over the step; the byte accepted this cycle already captured the old key.
    if (key_load) begin
      key_d = key_seed;
    end else if (accept) begin
      key_d = {key_q[6:0], key_q[7] ^ key_q[5] ^ key_q[4] ^ key_q[3]};
    end
    if (s1_valid_q) begin
      s2_data_d = s1_data_q ^ s1_key_q;
    end
    if (push) begin
      mem_d[wr_ptr_q] = s2_data_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= SEED;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_key_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
    end else begin
      key_q      <= key_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_key_q   <= s1_key_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DECRYPT_BYTE_CNT_EN
  logic [15:0] byte_count_q, byte_count_d;

  always_comb begin
    byte_count_d = byte_count_q;
    if (pop && (byte_count_q != 16'hFFFF)) begin
      byte_count_d = byte_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count_q <= '0;
    end else begin
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_count = byte_count_q;
`else
  // Without the counter, pops only advance the read pointer and the held output byte.
`endif

endmodule
